// File: rtl/rot_sched_pkg.sv
// Shared types and helpers for the round-robin rotate scheduler.
package rot_pkg;

    // Rotate direction as carried on req_dir.
    typedef enum logic {
        ROT_LEFT  = 1'b0,
        ROT_RIGHT = 1'b1
    } rot_dir_t;

    // Occupancy of a one-deep per-requester response slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Index that follows idx in a ring of n requesters.
    function automatic int next_rr_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rot_sched_rot_unit.sv
// Combinational barrel rotator. A left rotate by amt is performed as a right
// rotate by (-amt mod WIDTH), so only one log-depth stage network is needed.
module rot_unit #(
    parameter  int ROAMT_WIDTH = 5,
    localparam int WIDTH       = 2 ** ROAMT_WIDTH
) (
    input  logic [WIDTH-1:0]       val,
    input  logic [ROAMT_WIDTH-1:0] amt,
    input  logic                   dir,
    output logic [WIDTH-1:0]       out
);
    import rot_pkg::*;

    logic [ROAMT_WIDTH-1:0] effAmt;
    logic [WIDTH-1:0]       stage [ROAMT_WIDTH+1];

    // Fold the direction into a single right-rotate amount.
    always_comb begin
        effAmt = amt;
        if (rot_dir_t'(dir) == ROT_LEFT) begin
            effAmt = ROAMT_WIDTH'(0) - amt;
        end
    end

    assign stage[0] = val;

    for (genvar s = 0; s < ROAMT_WIDTH; s++) begin : gStage
        localparam int SH = 2 ** s;
        assign stage[s+1] = effAmt[s] ? {stage[s][SH-1:0], stage[s][WIDTH-1:SH]}
                                      : stage[s];
    end

    assign out = stage[ROAMT_WIDTH];

endmodule

// File: rtl/rot_sched.sv
// Round-robin scheduler sharing one barrel rotator among N_REQ requesters,
// each with a one-deep registered response slot.
module rot_sched #(
    parameter  int ROAMT_WIDTH = 5,
    parameter  int N_REQ       = 2,
    localparam int WIDTH       = 2 ** ROAMT_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_REQ-1:0]                    req_valid,
    output logic [N_REQ-1:0]                    req_ready,
    input  logic [N_REQ-1:0]                    req_dir,
    input  logic [N_REQ-1:0][ROAMT_WIDTH-1:0]   req_amt,
    input  logic [N_REQ-1:0][WIDTH-1:0]         req_val,
    output logic [N_REQ-1:0]                    resp_valid,
    input  logic [N_REQ-1:0]                    resp_ready,
    output logic [N_REQ-1:0][WIDTH-1:0]         resp_data
);
    import rot_pkg::*;

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    slot_state_t      slotState_q [N_REQ];
    slot_state_t      slotState_d [N_REQ];
    logic [WIDTH-1:0] respData_q  [N_REQ];
    logic [WIDTH-1:0] respData_d  [N_REQ];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    logic [N_REQ-1:0] eligible;
    logic             grantValid;
    logic [PTR_W-1:0] grantIdx;
    logic [PTR_W-1:0] candIdx;
    logic [WIDTH-1:0] rotOut;

    // Pick the first eligible requester at or after ptr, wrapping; no grant in reset.
    always_comb begin
        eligible   = '0;
        grantValid = 1'b0;
        grantIdx   = '0;
        candIdx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_valid[i] && ((slotState_q[i] == SLOT_EMPTY) || resp_ready[i]);
        end
        for (int k = 0; k < N_REQ; k++) begin
            candIdx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!grantValid && eligible[candIdx]) begin
                grantValid = 1'b1;
                grantIdx   = candIdx;
            end
        end
        grantValid = grantValid && !rst;
    end

    // One-hot ready for the winner only.
    always_comb begin
        req_ready = '0;
        if (grantValid) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    rot_unit #(
        .ROAMT_WIDTH(ROAMT_WIDTH)
    ) uRotUnit (
        .val(req_val[grantIdx]),
        .amt(req_amt[grantIdx]),
        .dir(req_dir[grantIdx]),
        .out(rotOut)
    );

    // Slot fill/drain and pointer advance for the coming edge.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            slotState_d[i] = slotState_q[i];
            respData_d[i]  = respData_q[i];
            if (grantValid && (grantIdx == PTR_W'(i))) begin
                slotState_d[i] = SLOT_FULL;
                respData_d[i]  = rotOut;
            end else if ((slotState_q[i] == SLOT_FULL) && resp_ready[i]) begin
                slotState_d[i] = SLOT_EMPTY;
            end
        end
        if (grantValid) begin
            ptr_d = PTR_W'(next_rr_idx(int'(grantIdx), N_REQ));
        end
    end

    // Response slots and round-robin pointer; reset empties everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                slotState_q[i] <= SLOT_EMPTY;
                respData_q[i]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < N_REQ; i++) begin
                slotState_q[i] <= slotState_d[i];
                respData_q[i]  <= respData_d[i];
            end
        end
    end

    // Expose slot registers directly so resp_ready never reaches these outputs.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = (slotState_q[i] == SLOT_FULL);
            resp_data[i]  = respData_q[i];
        end
    end

endmodule

// File: tb/tb_rot_sched.sv
// Testbench for rot_sched: directed scenarios followed by a randomized run,
// all checked against a behavioural model of slots, pointer and rotation.
module tb_rot_sched;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int N  = 2;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         req_dir;
    logic [N-1:0][AW-1:0] req_amt;
    logic [N-1:0][W-1:0]  req_val;
    logic [N-1:0]         resp_valid;
    logic [N-1:0]         resp_ready;
    logic [N-1:0][W-1:0]  resp_data;

    int           assertCount;
    int           failCount;
    logic         mValid [N];
    logic [W-1:0] mData  [N];
    int           mPtr;
    logic [N-1:0] lastReady;
    logic [N-1:0] lastExpReady;
    int           grantCnt [N];
    logic [W-1:0] heldData;

    rot_sched #(
        .ROAMT_WIDTH(AW),
        .N_REQ(N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_dir(req_dir),
        .req_amt(req_amt),
        .req_val(req_val),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit-by-bit rotation straight from the index formulas.
    function automatic logic [W-1:0] rotRef(input logic [W-1:0] v, input logic [AW-1:0] amt,
                                            input logic dir);
        logic [W-1:0] r;
        int a;
        a = int'(amt);
        for (int k = 0; k < W; k++) begin
            if (!dir) r[k] = v[(k - a + W) % W];
            else      r[k] = v[(k + a) % W];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mValid[i] = 1'b0;
            mData[i]  = '0;
        end
        mPtr = 0;
    endtask

    task automatic applyStimulus(input int i, input logic v, input logic d,
                                 input logic [AW-1:0] a, input logic [W-1:0] x);
        req_valid[i] = v;
        req_dir[i]   = d;
        req_amt[i]   = a;
        req_val[i]   = x;
    endtask

    // Inputs are driven at posedge+1; this checks ready before the edge,
    // advances the model, and checks the response slots after the edge.
    task automatic stepCycle();
        logic [N-1:0] elig;
        int win;
        int idx;
        #2;
        win = -1;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_valid[i] && (!mValid[i] || resp_ready[i]);
        end
        for (int k = 0; k < N; k++) begin
            idx = (mPtr + k) % N;
            if (win < 0 && elig[idx]) win = idx;
        end
        lastExpReady = '0;
        if (win >= 0) lastExpReady[win] = 1'b1;
        lastReady = req_ready;
        checkOutput("req_ready", req_ready, lastExpReady);
        for (int i = 0; i < N; i++) begin
            if (i == win) begin
                mValid[i] = 1'b1;
                mData[i]  = rotRef(req_val[i], req_amt[i], req_dir[i]);
                grantCnt[i]++;
            end else if (mValid[i] && resp_ready[i]) begin
                mValid[i] = 1'b0;
            end
        end
        if (win >= 0) mPtr = (win + 1) % N;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            checkOutput($sformatf("resp_valid[%0d]", i), resp_valid[i], mValid[i]);
            checkOutput($sformatf("resp_data[%0d]", i), resp_data[i], mData[i]);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        for (int i = 0; i < N; i++) grantCnt[i] = 0;
        lastExpReady = '0;
        lastReady    = '0;
        modelReset();

        // Reset state, with requests presented to prove ready is held low.
        rst        = 1'b1;
        resp_ready = '0;
        applyStimulus(0, 1'b1, 1'b0, 5'd0, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("rst_resp_valid", resp_valid, 2'b00);
        checkOutput("rst_resp_data0", resp_data[0], 32'h0);
        checkOutput("rst_resp_data1", resp_data[1], 32'h0);
        checkOutput("rst_req_ready", req_ready, 2'b00);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;

        // Left rotate by one on requester 0.
        resp_ready = 2'b11;
        applyStimulus(0, 1'b1, 1'b0, 5'd1, 32'h8000_0001);
        stepCycle();
        checkOutput("left1_ready", lastReady, 2'b01);
        checkOutput("left1_data", resp_data[0], 32'h0000_0003);
        req_valid = '0;

        // Right rotate by four on requester 1.
        applyStimulus(1, 1'b1, 1'b1, 5'd4, 32'h0000_00F1);
        stepCycle();
        checkOutput("right4_data", resp_data[1], 32'h1000_000F);
        req_valid = '0;

        // Zero amount is identity in both directions.
        applyStimulus(1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
        stepCycle();
        checkOutput("left0_data", resp_data[1], 32'hDEAD_BEEF);
        req_valid = '0;
        applyStimulus(0, 1'b1, 1'b1, 5'd0, 32'h1234_5678);
        stepCycle();
        checkOutput("right0_data", resp_data[0], 32'h1234_5678);
        req_valid = '0;

        // Fairness: both continuously valid from reset alternate starting at 0.
        doReset();
        for (int i = 0; i < N; i++) grantCnt[i] = 0;
        resp_ready = 2'b11;
        for (int i = 0; i < N; i++) begin
            applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        end
        for (int c = 0; c < 8; c++) begin
            stepCycle();
            checkOutput($sformatf("fair_grant_c%0d", c), lastReady, (c % 2 == 0) ? 2'b01 : 2'b10);
            for (int i = 0; i < N; i++) begin
                if (lastExpReady[i]) begin
                    applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                                  $urandom);
                end
            end
        end
        checkOutput("fair_cnt0", 64'(grantCnt[0]), 64'd4);
        checkOutput("fair_cnt1", 64'(grantCnt[1]), 64'd4);

        // Back-pressure on consumer 0: fill slot 0 and hold it.
        resp_ready = 2'b10;
        stepCycle();
        checkOutput("bp_fill_ready", lastReady, 2'b01);
        heldData = mData[0];
        for (int i = 0; i < N; i++) begin
            if (lastExpReady[i]) begin
                applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                              $urandom);
            end
        end
        for (int c = 0; c < 4; c++) begin
            stepCycle();
            checkOutput($sformatf("bp_ready_c%0d", c), lastReady, 2'b10);
            checkOutput($sformatf("bp_hold_c%0d", c), resp_data[0], heldData);
            applyStimulus(1, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom);
        end
        resp_ready = 2'b11;
        stepCycle();
        checkOutput("bp_release_ready", lastReady, 2'b01);

        // Single requester back-to-back at full rate.
        req_valid[1] = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 5'd31, 32'd1);
        stepCycle();
        checkOutput("b2b_1", resp_data[0], 32'h8000_0000);
        applyStimulus(0, 1'b1, 1'b0, 5'd31, 32'd2);
        stepCycle();
        checkOutput("b2b_2", resp_data[0], 32'h0000_0001);
        applyStimulus(0, 1'b1, 1'b0, 5'd31, 32'd3);
        stepCycle();
        checkOutput("b2b_3", resp_data[0], 32'h8000_0001);

        // Fill both slots with ptr left at 1, then reset mid-operation.
        resp_ready = 2'b00;
        req_valid  = '0;
        applyStimulus(1, 1'b1, 1'b1, 5'd7, 32'hA5A5_0F0F);
        stepCycle();
        req_valid = '0;
        resp_ready = 2'b01;
        applyStimulus(0, 1'b1, 1'b0, 5'd9, 32'h0BAD_CAFE);
        stepCycle();
        checkOutput("pre_rst_full", resp_valid, 2'b11);
        resp_ready = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", resp_valid, 2'b00);
        checkOutput("async_rst_data0", resp_data[0], 32'h0);
        checkOutput("async_rst_data1", resp_data[1], 32'h0);
        checkOutput("async_rst_ready", req_ready, 2'b00);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 2'b11;
        applyStimulus(0, 1'b1, 1'b1, 5'd3, 32'h1111_2222);
        applyStimulus(1, 1'b1, 1'b0, 5'd5, 32'h3333_4444);
        stepCycle();
        checkOutput("post_rst_first_grant", lastReady, 2'b01);

        // Randomized traffic honouring the hold-while-not-accepted rule.
        for (int c = 0; c < 300; c++) begin
            resp_ready = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !lastExpReady[i])) begin
                    applyStimulus(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                                  AW'($urandom_range(0, 31)), $urandom);
                end
            end
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rot_sched.md
# rot_sched

Round-robin scheduler that shares one combinational barrel rotator among `N_REQ` requesters. Each requester issues rotate-left or rotate-right operations through a valid/ready request channel. Each requester also owns a one-deep registered response slot with its own valid/ready handshake. The block sits between several pipeline clients that need occasional rotates and the single rotator instance, so that rotator area is not duplicated.

## Interface
- `ROAMT_WIDTH`, 5: rotate-amount width; data width `WIDTH = 2**ROAMT_WIDTH`.
- `N_REQ`, 2: number of requesters, at least 2.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `req_valid` in, [N_REQ]: request i is presented.
- `req_ready` out, [N_REQ]: request i is accepted this cycle.
- `req_dir` in, [N_REQ]: 0 = rotate left, 1 = rotate right.
- `req_amt` in, [N_REQ][ROAMT_WIDTH]: rotate amount.
- `req_val` in, [N_REQ][WIDTH]: operand.
- `resp_valid` out, [N_REQ]: response slot i is full.
- `resp_ready` in, [N_REQ]: consumer i takes the response.
- `resp_data` out, [N_REQ][WIDTH]: rotated result.

## Operation
- Slot i is free in a cycle if `!resp_valid[i] || resp_ready[i]`. A drain and a refill can happen in the same cycle.
- Eligible set: requesters i with `req_valid[i]` set and slot i free.
- Arbitration: round-robin pointer `ptr` of width ceil(log2 N_REQ).
  - The first eligible index, searching upward from `ptr` and wrapping, wins.
  - At most one grant per cycle.
- `req_ready[w]` is 1 only for the winner w and is combinational from the current-cycle `req_valid`, slot state and `ptr`.
- On grant:
  - `resp_data[w] <= rot(req_val[w], req_amt[w], req_dir[w])`.
  - `resp_valid[w] <= 1`.
  - `ptr <= (w+1) mod N_REQ`.
- With no grant, `ptr` holds.
- Drain without refill: `resp_valid[i] <= 0` when `resp_valid[i] && resp_ready[i]` and i is not granted.
- Rotate arithmetic:
  - Left: `out[k] = val[(k - amt) mod WIDTH]`.
  - Right: `out[k] = val[(k + amt) mod WIDTH]`.
  - `amt = 0` gives `out = val` in both directions; there is no zero-fill artefact.
- Response-slot state per requester: EMPTY to FULL on grant. FULL to EMPTY on drain without grant. FULL stays FULL on drain with grant; new data is loaded.
- Request-side rules:
  - Requester i must hold `req_*[i]` stable while `req_valid[i] && !req_ready[i]`.
  - The block never drops or reorders operations of the same requester.
- Response-side rule: `resp_data[i]` is stable while `resp_valid[i] && !resp_ready[i]`.

## Timing
- Reset values: `ptr = 0`, `resp_valid = 0`, `resp_data = 0`. `req_ready` is 0 while `rst` is asserted.
- Latency: a request accepted at edge T shows `resp_valid` high and valid `resp_data` from T+1.
- Throughput:
  - 1 operation per cycle in aggregate.
  - A single active requester whose consumer holds `resp_ready = 1` gets 1 per cycle.
- Fairness: with all requesters continuously eligible, grants rotate 0, 1, …, N_REQ-1, 0, …
- Reset asserted mid-operation:
  - All slots empty immediately (asynchronously).
  - Pending results are discarded.
  - `ptr` returns to 0.
  - The first grant after deassertion goes to the lowest eligible index.
- There is no combinational path from `resp_ready` to `resp_valid` or `resp_data`.
- `req_ready` depends combinationally on `resp_ready`, which is the permitted path.

## Structure
- Package `rot_pkg`:
  - `typedef enum logic {ROT_LEFT=0, ROT_RIGHT=1} rot_dir_t`.
  - Helper function for next round-robin index.
- Sub-module `rot_unit`: one combinational direction-selectable rotator parameterised by `ROAMT_WIDTH`, with ports `val`, `amt`, `dir`, `out`. Instantiate it exactly once and feed it through the grant mux.
- Top level contains: arbiter, operand mux, per-requester response registers, `ptr` register.

## Test plan
- Reset, then `N_REQ=2`; req0 left, `val=32'h8000_0001`, `amt=1` → `req_ready[0]` in the same cycle; next cycle `resp_valid[0]=1`, `resp_data[0]=32'h0000_0003`.
- Req1 right, `val=32'h0000_00F1`, `amt=4` → `resp_data[1]=32'h1000_000F`. Then `amt=0` → `resp_data` equals `val` for both directions.
- Both requesters valid every cycle, both `resp_ready=1`, for 8 cycles → grants alternate 0, 1, 0, 1, …, starting with 0 after reset; 4 results per requester; no data mixing.
- `resp_ready[0]=0` holding a full slot, req0 and req1 valid → req0 never granted and `resp_data[0]` stable; req1 granted every cycle. Raise `resp_ready[0]` → req0 granted in that same cycle.
- Consumer 0 `resp_ready=1`, req0 alone valid with back-to-back operands 1, 2, 3 at `amt=31` left → one result per cycle: `32'h8000_0000`, `32'h0000_0001`, `32'h8000_0001`.
- Assert `rst` for 1 cycle while `resp_valid=2'b11` → both `resp_valid` drop immediately with no clock edge; after release, next eligible grant is index 0.
